// File: rtl/display_shadow_bridge_if.sv
// Processor data-bus view of the display shadow bridge: store strobe, address and
// data from the core, plus the window hit flag and readback byte returned to it.
interface display_shadow_bridge_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        rd_hit;
  logic [7:0]  rd_data;

  modport master (
    output MemWrite, DataAdr, WriteData,
    input  rd_hit, rd_data
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    output rd_hit, rd_data
  );
endinterface

// File: rtl/display_shadow_bridge.sv
// Double-buffered display register bank snooping processor stores; the back buffer is
// copied to the front buffer only at frame start so the byte shown to VGA never tears.
module display_shadow_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0040,
  parameter int          NUM_REGS  = 4,
  parameter logic [7:0]  INIT_VAL  = 8'h63
) (
  input  logic                    clk,
  input  logic                    rst,
  display_shadow_bridge_if.slave  bus,
  input  logic                    vsync,
  input  logic [1:0]              disp_sel,
  output logic [7:0]              disp_data,
  output logic [15:0]             frame_count,
  output logic                    busy
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] COPY  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          dirty;
  logic          auto_en;
  logic          pend;
  logic [7:0]    back  [NUM_REGS];
  logic [7:0]    front [NUM_REGS];
  logic          vs_s1, vs_s2, vs_s3;

  logic [31:0]   off;
  logic [IW-1:0] wr_idx;
  logic          reg_hit, ctrl_hit;
  logic          reg_wr, ctrl_wr, commit_req;
  logic          frame_tick;
  logic          enter_copy;
  logic          unused_data;

  assign off        = bus.DataAdr - BASE_ADDR;
  assign wr_idx     = off[IW-1:0];
  assign reg_hit    = off < 32'(NUM_REGS);
  assign ctrl_hit   = off == 32'(NUM_REGS);
  assign reg_wr     = bus.MemWrite & reg_hit;
  assign ctrl_wr    = bus.MemWrite & ctrl_hit;
  assign commit_req = ctrl_wr & bus.WriteData[0];
  assign unused_data = ^bus.WriteData[31:8];

  assign bus.rd_hit = reg_hit | ctrl_hit;
  assign busy       = state != IDLE;
  assign frame_tick = vs_s3 & ~vs_s2;

  // A commit request in IDLE beats a simultaneous auto-copy; the copy then waits a frame.
  assign enter_copy = ((state == IDLE) & ~commit_req & auto_en & dirty & frame_tick) |
                      ((state == ARMED) & frame_tick);

  always_comb begin
    bus.rd_data = 8'h00;
    if (reg_hit)
      bus.rd_data = back[wr_idx];
    else if (ctrl_hit)
      bus.rd_data = {4'b0000, busy, state == ARMED, auto_en, dirty};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1       <= 1'b1;
      vs_s2       <= 1'b1;
      vs_s3       <= 1'b1;
      frame_count <= 16'h0000;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      if (frame_tick)
        frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        back[i] <= INIT_VAL;
    end else if (reg_wr) begin
      back[wr_idx] <= bus.WriteData[7:0];
    end
  end

  // The front copy reads back[idx] before any same-edge store lands, so it takes the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        front[i] <= INIT_VAL;
    end else if (state == COPY) begin
      front[idx] <= back[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      disp_data <= INIT_VAL;
    else if (32'(disp_sel) < 32'(NUM_REGS))
      disp_data <= front[disp_sel];
    else
      disp_data <= 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      dirty   <= 1'b0;
      auto_en <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (ctrl_wr)
        auto_en <= bus.WriteData[1];

      if (reg_wr)
        dirty <= 1'b1;
      else if (enter_copy)
        dirty <= 1'b0;

      case (state)
        IDLE: begin
          if (commit_req) begin
            state <= ARMED;
          end else if (enter_copy) begin
            state <= COPY;
            idx   <= '0;
          end
        end
        ARMED: begin
          if (enter_copy) begin
            state <= COPY;
            idx   <= '0;
          end
        end
        COPY: begin
          if (idx == LAST_IDX) begin
            state <= (pend | commit_req) ? ARMED : IDLE;
            pend  <= 1'b0;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
            if (commit_req)
              pend <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_shadow_bridge.sv
// Bench for display_shadow_bridge: directed frame scenarios plus random bus/vsync traffic,
// compared every cycle against a frame-level model of the double-buffered register bank.
module tb_display_shadow_bridge;

  localparam logic [31:0] BASE = 32'h0000_0040;
  localparam int          N    = 4;
  localparam logic [7:0]  INIT = 8'h63;
  localparam logic [31:0] CTRL = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [1:0]  disp_sel;
  logic [7:0]  disp_data;
  logic [15:0] frame_count;
  logic        busy;

  display_shadow_bridge_if bus ();

  display_shadow_bridge #(
    .BASE_ADDR (BASE),
    .NUM_REGS  (N),
    .INIT_VAL  (INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .vsync       (vsync),
    .disp_sel    (disp_sel),
    .disp_data   (disp_data),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model state: buffers, flags, and the position of an in-flight copy (-1 when none).
  logic [7:0]  m_back  [N];
  logic [7:0]  m_front [N];
  logic [7:0]  m_disp;
  logic [15:0] m_fc;
  bit          m_dirty, m_auto, m_armed, m_pend;
  int          m_copy_pos;
  logic        m_vs [3];
  logic [31:0] mt_off;
  bit          mt_tick, mt_reg, mt_ctrl, mt_commit;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelBusy();
    return m_armed || (m_copy_pos >= 0);
  endfunction

  function automatic logic [7:0] modelRead(input logic [31:0] addr);
    logic [31:0] a;
    a = addr - BASE;
    if (a < 32'(N)) return m_back[a[1:0]];
    if (a == 32'(N)) return {4'b0000, modelBusy(), m_armed, m_auto, m_dirty};
    return 8'h00;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_back[i]  = INIT;
      m_front[i] = INIT;
    end
    m_disp     = INIT;
    m_fc       = 16'h0000;
    m_dirty    = 1'b0;
    m_auto     = 1'b0;
    m_armed    = 1'b0;
    m_pend     = 1'b0;
    m_copy_pos = -1;
    m_vs       = '{1'b1, 1'b1, 1'b1};
  endtask

  // A frame starts when vsync, seen through two sync stages, goes from high to low.
  task automatic modelStep();
    mt_tick = m_vs[2] & ~m_vs[1];
    m_vs[2] = m_vs[1];
    m_vs[1] = m_vs[0];
    m_vs[0] = vsync;
    mt_off    = bus.DataAdr - BASE;
    mt_reg    = bus.MemWrite && (mt_off < 32'(N));
    mt_ctrl   = bus.MemWrite && (mt_off == 32'(N));
    mt_commit = mt_ctrl && bus.WriteData[0];
    m_disp = (32'(disp_sel) < 32'(N)) ? m_front[disp_sel] : 8'h00;
    if (mt_tick) m_fc = m_fc + 16'd1;
    if (m_copy_pos >= 0) begin
      m_front[m_copy_pos] = m_back[m_copy_pos];
      if (mt_commit) m_pend = 1'b1;
      m_copy_pos++;
      if (m_copy_pos == N) begin
        m_copy_pos = -1;
        m_armed    = m_pend;
        m_pend     = 1'b0;
      end
    end else if (m_armed) begin
      if (mt_tick) begin
        m_armed    = 1'b0;
        m_copy_pos = 0;
        m_dirty    = 1'b0;
      end
    end else if (mt_commit) begin
      m_armed = 1'b1;
    end else if (m_auto && m_dirty && mt_tick) begin
      m_copy_pos = 0;
      m_dirty    = 1'b0;
    end
    if (mt_reg) begin
      m_back[mt_off[1:0]] = bus.WriteData[7:0];
      m_dirty = 1'b1;
    end
    if (mt_ctrl) m_auto = bus.WriteData[1];
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst === 1'b1) modelReset();
    else modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en && rst === 1'b0) begin
      checkOutput("disp_data",   disp_data,   m_disp);
      checkOutput("frame_count", frame_count, m_fc);
      checkOutput("busy",        busy,        modelBusy());
      checkOutput("rd_hit",      bus.rd_hit,  (bus.DataAdr - BASE) <= 32'(N));
      checkOutput("rd_data",     bus.rd_data, modelRead(bus.DataAdr));
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic vs, input logic [1:0] sel);
    @(posedge clk);
    #1;
    bus.MemWrite  = we;
    bus.DataAdr   = addr;
    bus.WriteData = wd;
    vsync         = vs;
    disp_sel      = sel;
  endtask

  task automatic idleCycles(input int n, input logic [31:0] addr, input logic [1:0] sel);
    repeat (n) applyStimulus(1'b0, addr, 32'h0, 1'b1, sel);
  endtask

  task automatic frame(input logic [31:0] addr, input logic [1:0] sel);
    applyStimulus(1'b0, addr, 32'h0, 1'b0, sel);
    applyStimulus(1'b0, addr, 32'h0, 1'b0, sel);
    idleCycles(10, addr, sel);
  endtask

  int copy_cycles;
  int busy_seen;
  int vs_period;
  int vs_cnt;
  logic        r_we;
  logic [31:0] r_addr;

  initial begin
    rst           = 1'b1;
    vsync         = 1'b1;
    disp_sel      = 2'd0;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = CTRL;
    bus.WriteData = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    cmp_en = 1'b1;

    for (int s = 0; s < N; s++) begin
      applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'(s));
      applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'(s));
      @(negedge clk);
      checkOutput("reset_disp", disp_data, 8'h63);
    end
    checkOutput("reset_frame_count", frame_count, 16'h0000);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ctrl_read", bus.rd_data, 8'h00);

    // Store without commit: front buffer must keep the reset byte across frames.
    applyStimulus(1'b1, BASE + 32'd1, 32'hDEAD_BEA5, 1'b1, 2'd1);
    repeat (3) frame(CTRL, 2'd1);
    @(negedge clk);
    checkOutput("nocommit_disp", disp_data, 8'h63);
    checkOutput("nocommit_frames", frame_count, 16'd3);
    checkOutput("nocommit_ctrl", bus.rd_data, 8'h01);
    applyStimulus(1'b0, BASE + 32'd1, 32'h0, 1'b1, 2'd1);
    @(negedge clk);
    checkOutput("nocommit_back", bus.rd_data, 8'hA5);

    applyStimulus(1'b1, BASE + 32'd2, 32'h0000_003C, 1'b1, 2'd2);
    applyStimulus(1'b1, CTRL, 32'h1, 1'b1, 2'd2);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd2);
    @(negedge clk);
    checkOutput("armed_ctrl", bus.rd_data, 8'h0D);
    copy_cycles = 0;
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd2);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd2);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd2);
      @(negedge clk);
      if (bus.rd_data[3:2] == 2'b10) copy_cycles++;
    end
    checkOutput("copy_cycles", copy_cycles, 4);
    checkOutput("commit_disp2", disp_data, 8'h3C);
    checkOutput("commit_ctrl", bus.rd_data, 8'h00);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    @(negedge clk);
    checkOutput("commit_disp1", disp_data, 8'hA5);

    // Auto mode: each frame with a store publishes it; a quiet frame must not copy.
    applyStimulus(1'b1, CTRL, 32'h2, 1'b1, 2'd0);
    applyStimulus(1'b1, BASE, 32'h11, 1'b1, 2'd0);
    frame(CTRL, 2'd0);
    @(negedge clk);
    checkOutput("auto_disp_11", disp_data, 8'h11);
    applyStimulus(1'b1, BASE, 32'h5A, 1'b1, 2'd0);
    @(negedge clk);
    checkOutput("auto_before_frame", disp_data, 8'h11);
    frame(CTRL, 2'd0);
    @(negedge clk);
    checkOutput("auto_disp_5a", disp_data, 8'h5A);
    busy_seen = 0;
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd0);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd0);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd0);
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checkOutput("auto_quiet_frame", busy_seen, 0);

    // Store to the register being copied, then a commit inside the copy window.
    applyStimulus(1'b1, BASE + 32'd1, 32'h77, 1'b1, 2'd1);
    applyStimulus(1'b1, CTRL, 32'h1, 1'b1, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    applyStimulus(1'b1, BASE + 32'd1, 32'hFF, 1'b1, 2'd1);
    applyStimulus(1'b1, CTRL, 32'h1, 1'b1, 2'd1);
    idleCycles(4, CTRL, 2'd1);
    @(negedge clk);
    checkOutput("copy_race_front", disp_data, 8'h77);
    checkOutput("copy_race_ctrl", bus.rd_data, 8'h0D);
    applyStimulus(1'b0, BASE + 32'd1, 32'h0, 1'b1, 2'd1);
    @(negedge clk);
    checkOutput("copy_race_back", bus.rd_data, 8'hFF);

    $display("[TB] random traffic phase");
    vs_period = 12;
    vs_cnt    = 0;
    for (int i = 0; i < 3000; i++) begin
      r_we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: r_addr = BASE + 32'($urandom_range(0, 4));
        6:                r_addr = BASE - 32'd1;
        7:                r_addr = BASE + 32'd5;
        default:          r_addr = $urandom;
      endcase
      vs_cnt++;
      if (vs_cnt >= vs_period) begin
        vs_cnt    = 0;
        vs_period = int'($urandom_range(6, 20));
      end
      applyStimulus(r_we, r_addr, $urandom, (vs_cnt >= 2), 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a copy must restore everything without waiting for a clock.
    idleCycles(12, CTRL, 2'd1);
    applyStimulus(1'b1, CTRL, 32'h1, 1'b1, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b0, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    applyStimulus(1'b0, CTRL, 32'h0, 1'b1, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midcopy_rst_disp", disp_data, 8'h63);
    checkOutput("midcopy_rst_frames", frame_count, 16'h0000);
    checkOutput("midcopy_rst_busy", busy, 1'b0);
    checkOutput("midcopy_rst_ctrl", bus.rd_data, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;

    idleCycles(2, CTRL, 2'd0);
    @(negedge clk);
    force dut.frame_count = 16'hFFFE;
    m_fc = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count;
    frame(CTRL, 2'd0);
    @(negedge clk);
    checkOutput("frame_count_ffff", frame_count, 16'hFFFF);
    frame(CTRL, 2'd0);
    @(negedge clk);
    checkOutput("frame_count_wrap", frame_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
